remote_comm_e: RTL and testbench

REMOTE_COMM_E -- requirements
Module: remote_comm_e

---
 rtl/remote_comm_e.sv | 191 +++++++++++++++++++
 tb/tb_remote_comm_e.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/remote_comm_e.sv
// Full-duplex UART link to the robot: sends a 16-bit command as two 8N1 bytes
// (high byte first) and captures response bytes arriving on RX.
module remote_comm_e #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} tx_state_e;
  typedef enum logic {RX_IDLE, RX_BUSY} rx_state_e;

  // ---------------- transmit path ----------------
  tx_state_e       state_q, state_d;
  logic [7:0]      lo_hold_q, lo_hold_d;
  logic [8:0]      tx_shift_q, tx_shift_d;
  logic [CW-1:0]   tx_baud_q, tx_baud_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic            tx_q, tx_d;
  logic            cmd_sent_q, cmd_sent_d;
  logic            tx_bit_end, tx_frame_end;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d    = state_q;
    lo_hold_d  = lo_hold_q;
    tx_shift_d = tx_shift_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    cmd_sent_d = cmd_sent_q;

    tx_bit_end   = (tx_baud_q == BAUD_LAST);
    tx_frame_end = tx_bit_end && (tx_bit_q == 4'd9);

    if (state_q != IDLE) begin
      tx_baud_d = tx_bit_end ? '0 : tx_baud_q + CW'(1);
      if (tx_bit_end && !tx_frame_end) begin
        tx_d       = tx_shift_q[0];
        tx_shift_d = {1'b1, tx_shift_q[8:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (send_cmd) begin
          lo_hold_d  = cmd[7:0];
          tx_d       = 1'b0;
          tx_shift_d = {1'b1, cmd[15:8]};
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          cmd_sent_d = 1'b0;
          state_d    = SEND_HI;
        end
      end
      SEND_HI: begin
        // Low byte's start bit begins on the very edge the high stop bit ends.
        if (tx_frame_end) begin
          tx_d       = 1'b0;
          tx_shift_d = {1'b1, lo_hold_q};
          tx_bit_d   = '0;
          state_d    = SEND_LO;
        end
      end
      SEND_LO: begin
        if (tx_frame_end) begin
          tx_d       = 1'b1;
          tx_bit_d   = '0;
          cmd_sent_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lo_hold_q  <= '0;
      tx_shift_q <= '1;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
      cmd_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_hold_q  <= lo_hold_d;
      tx_shift_q <= tx_shift_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
      cmd_sent_q <= cmd_sent_d;
    end
  end

  // ---------------- receive path ----------------
  rx_state_e       rx_state_q, rx_state_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0]   rx_baud_q, rx_baud_d;
  logic [3:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      resp_q, resp_d;
  logic            resp_rdy_q, resp_rdy_d;
  logic            start_det, rx_sample, rx_done;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    resp_d     = resp_q;
    resp_rdy_d = resp_rdy_q;
    rx_done    = 1'b0;

    start_det = (rx_state_q == RX_IDLE) && rx_prev_q && !rx_sync_q;
    // Sample 0 lands mid start bit, later samples one full bit apart.
    rx_sample = (rx_state_q == RX_BUSY) &&
                (rx_baud_q == ((rx_bit_q == 4'd0) ? HALF_LAST : BAUD_LAST));

    if (start_det) begin
      rx_state_d = RX_BUSY;
      rx_baud_d  = '0;
      rx_bit_d   = '0;
    end else if (rx_state_q == RX_BUSY) begin
      if (rx_sample) begin
        rx_baud_d = '0;
        rx_bit_d  = rx_bit_q + 4'd1;
        if (rx_bit_q >= 4'd1 && rx_bit_q <= 4'd8) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        end
        if (rx_bit_q == 4'd9) begin
          rx_done    = 1'b1;
          resp_d     = rx_shift_q;
          rx_bit_d   = '0;
          rx_state_d = RX_IDLE;
        end
      end else begin
        rx_baud_d = rx_baud_q + CW'(1);
      end
    end

    if (rx_done)      resp_rdy_d = 1'b1;
    if (start_det)    resp_rdy_d = 1'b0;
    // An X/Z on clr_resp_rdy fails the if-test, so a floating input reads as 0.
    if (clr_resp_rdy) resp_rdy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

  assign TX       = tx_q;
  assign cmd_sent = cmd_sent_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm_e.sv
// Bench for remote_comm_e: timing-level UART model checked every cycle, plus
// directed command/response scenarios with hand-computed bit patterns.
module tb_remote_comm_e;

  localparam int B    = 16;
  localparam int HALF = B / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        send_cmd = 1'b0;
  logic        clr_resp_rdy = 1'b0;
  logic [15:0] cmd = '0;
  logic        tx, cmd_sent, resp_rdy;
  logic [7:0]  resp;
  logic        rx_line;

  assign rx_line = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  remote_comm_e #(.BAUD_DIV(B)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RX           (rx_line),
    .TX           (tx),
    .cmd          (cmd),
    .send_cmd     (send_cmd),
    .cmd_sent     (cmd_sent),
    .resp         (resp),
    .resp_rdy     (resp_rdy),
    .clr_resp_rdy (clr_resp_rdy)
  );

  int     checks = 0;
  int     errors = 0;
  int     shown  = 0;
  longint cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // TX: a command is a 20-bit line pattern, each bit held B clocks from the accept edge.
  // RX: a line fall reaches the detector 3 edges later (2 sync flops + edge detect);
  //     the byte is ready HALF + 9*B edges after detection.
  logic        exp_tx = 1'b1, exp_sent = 1'b0, exp_rdy = 1'b0;
  logic [7:0]  exp_resp = '0;
  bit          tx_active = 1'b0;
  longint      tx_start = 0;
  logic [19:0] tx_pat = '1;
  longint      rx_free = 0, det_edge = -1, stop_edge = -1;
  logic        lprev = 1'b1;
  logic [7:0]  pend_byte = '0;
  logic [7:0]  rx_q[$];

  always @(negedge clk) begin : model
    longint m;
    int     idx;
    m = cyc + 1;
    if (!rst_n) begin
      exp_tx = 1'b1; exp_sent = 1'b0; exp_rdy = 1'b0; exp_resp = '0;
      tx_active = 1'b0; rx_free = 0; det_edge = -1; stop_edge = -1; lprev = 1'b1;
    end else begin
      if (!tx_active && send_cmd) begin
        tx_active = 1'b1;
        tx_start  = m;
        tx_pat    = {1'b1, cmd[7:0], 1'b0, 1'b1, cmd[15:8], 1'b0};
        exp_tx    = 1'b0;
        exp_sent  = 1'b0;
      end else if (tx_active) begin
        if (m < tx_start + 20 * B) begin
          idx    = int'((m - tx_start) / B);
          exp_tx = tx_pat[idx];
        end else begin
          exp_tx = 1'b1; exp_sent = 1'b1; tx_active = 1'b0;
        end
      end
      if (lprev && !rx_line && (cyc + 2 >= rx_free)) begin
        det_edge  = cyc + 3;
        stop_edge = det_edge + HALF + 9 * B;
        rx_free   = stop_edge;
        if (rx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_unexpected_start cyc=%0d actual=start expected=none", cyc);
          pend_byte = '0;
        end else begin
          pend_byte = rx_q.pop_front();
        end
      end
      lprev = rx_line;
      if (m == stop_edge) begin exp_rdy = 1'b1; exp_resp = pend_byte; end
      if (m == det_edge)  exp_rdy = 1'b0;
      if (clr_resp_rdy)   exp_rdy = 1'b0;
    end
  end

  always @(posedge clk) begin : compare
    cyc++;
    #1;
    checks++;
    if ({tx, cmd_sent, resp_rdy, resp} !== {exp_tx, exp_sent, exp_rdy, exp_resp}) begin
      errors++;
      if (shown < 10) begin
        shown++;
        $display("FAIL cycle_cmp cyc=%0d actual tx=%b sent=%b rdy=%b resp=%h expected tx=%b sent=%b rdy=%b resp=%h",
                 cyc, tx, cmd_sent, resp_rdy, resp, exp_tx, exp_sent, exp_rdy, exp_resp);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_cmd(input logic [15:0] c, input int inject_at,
                         output logic [19:0] pat, output int lat, output int rises);
    logic prev;
    pat = '0; lat = -1; rises = 0; prev = 1'b0;
    rst_n = 1'b1; cmd = c; send_cmd = 1'b1;
    step();
    send_cmd = 1'b0;
    cmd = 16'hFFFF;
    for (int k = 0; k < 20 * B + 4; k++) begin
      if (k > 0) step();
      if ((k % B) == HALF && (k / B) < 20) pat = {pat[18:0], tx};
      if (cmd_sent && !prev) begin
        rises++;
        if (lat < 0) lat = k;
      end
      prev = cmd_sent;
      send_cmd = (k == inject_at);
      if (k == inject_at) cmd = 16'h1234;
    end
    send_cmd = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit with_clr);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int c = 0; c < 10 * B; c++) begin
      if (c > 0) step();
      rx_drv = fr[c / B];
      clr_resp_rdy = with_clr && (c == 2 + HALF + 9 * B);
    end
    step();
    rx_drv = 1'b1;
    clr_resp_rdy = 1'b0;
  endtask

  function automatic logic lat_ok(input int lat);
    return (lat >= 20 * B) && (lat <= 20 * B + 2);
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    logic [19:0] pat;
    int          lat, rises, rdy_rises;
    logic [7:0]  r1;
    bit          got1;
    logic        prev_rdy;

    repeat (3) step();
    check("reset_tx", tx, 1'b1);
    check("reset_cmd_sent", cmd_sent, 1'b0);
    check("reset_resp_rdy", resp_rdy, 1'b0);
    check("reset_resp", resp, 8'h00);

    // send on first edge after reset release, 0x4001
    run_cmd(16'h4001, -1, pat, lat, rises);
    check("pat_4001", pat, 20'h01501);
    check("lat_4001_in_window", lat_ok(lat), 1'b1);
    check("rises_4001", rises, 1);

    // second request mid high byte is ignored
    run_cmd(16'h6022, 5 * B, pat, lat, rises);
    check("pat_6022", pat, 20'h03489);
    check("lat_6022_in_window", lat_ok(lat), 1'b1);
    check("rises_6022", rises, 1);
    repeat (3) step();
    check("cmd_sent_held", cmd_sent, 1'b1);

    // external byte, then a byte whose completion collides with clr
    rx_q.push_back(8'hA5);
    send_rx(8'hA5, 1'b0);
    check("rx_a5_resp", resp, 8'hA5);
    check("rx_a5_rdy", resp_rdy, 1'b1);
    check("rx_a5_cmd_sent", cmd_sent, 1'b1);
    rx_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    check("clr_wins_rdy", resp_rdy, 1'b0);
    check("clr_wins_resp", resp, 8'h3C);

    // loopback 0x5BF2
    loop_en = 1'b1;
    rx_q.push_back(8'h5B);
    rx_q.push_back(8'hF2);
    cmd = 16'h5BF2; send_cmd = 1'b1;
    step();
    send_cmd = 1'b0;
    got1 = 1'b0; r1 = '0; rdy_rises = 0; prev_rdy = resp_rdy;
    for (int k = 0; k < 22 * B; k++) begin
      step();
      if (resp_rdy && !got1) begin r1 = resp; got1 = 1'b1; end
      if (resp_rdy && !prev_rdy) rdy_rises++;
      prev_rdy = resp_rdy;
    end
    check("loop_first_seen", got1, 1'b1);
    check("loop_first_resp", r1, 8'h5B);
    check("loop_rdy_rises", rdy_rises, 2);
    check("loop_second_resp", resp, 8'hF2);
    check("loop_second_rdy", resp_rdy, 1'b1);
    clr_resp_rdy = 1'b1;
    step();
    clr_resp_rdy = 1'b0;
    check("loop_clr_rdy", resp_rdy, 1'b0);
    check("loop_resp_held", resp, 8'hF2);
    loop_en = 1'b0;

    // reset mid high-byte bit, then a fresh command
    cmd = 16'hA55A; send_cmd = 1'b1;
    step();
    send_cmd = 1'b0;
    repeat (B + 3) step();
    rst_n = 1'b0;
    #1;
    check("midreset_tx", tx, 1'b1);
    check("midreset_cmd_sent", cmd_sent, 1'b0);
    repeat (2) step();
    check("midreset_tx_held", tx, 1'b1);
    run_cmd(16'h4001, -1, pat, lat, rises);
    check("pat_after_reset", pat, 20'h01501);
    check("lat_after_reset_in_window", lat_ok(lat), 1'b1);
    check("rises_after_reset", rises, 1);

    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
